// File: rtl/ext_burst_addrgen_if.sv
// rtl/ext_burst_addrgen_if.sv - external data bus and internal memory port bundle for ext_burst_addrgen
interface ext_burst_addrgen_if #(
    parameter int DATA_W       = 32,
    parameter int IO_ADDR_W    = 32,
    parameter int EXT_PERIOD_W = 10,
    parameter int MEM_ADDR_W   = 10
);
    // external burst bus
    logic                    databus_valid;
    logic                    databus_ready;
    logic [IO_ADDR_W-1:0]    databus_addr;
    logic [EXT_PERIOD_W-1:0] databus_len;
    logic                    databus_last;
    logic [DATA_W-1:0]       databus_rdata;
    logic [DATA_W-1:0]       databus_wdata;
    logic [DATA_W/8-1:0]     databus_wstrb;

    // internal memory port
    logic                    valid;
    logic                    we;
    logic [MEM_ADDR_W-1:0]   addr;
    logic [DATA_W-1:0]       data_out;
    logic [DATA_W-1:0]       data_in;

    modport master (
        output databus_valid, databus_addr, databus_len, databus_last,
               databus_wdata, databus_wstrb,
               valid, we, addr, data_out,
        input  databus_ready, databus_rdata, data_in
    );

    modport slave (
        input  databus_valid, databus_addr, databus_len, databus_last,
               databus_wdata, databus_wstrb,
               valid, we, addr, data_out,
        output databus_ready, databus_rdata, data_in
    );
endinterface

// File: rtl/ext_burst_addrgen.sv
// rtl/ext_burst_addrgen.sv - 2D strided burst address generator between external bus and internal memory (optional EXT_ADDRGEN_STALL_CNT_EN)
module ext_burst_addrgen #(
    parameter int DATA_W       = 32,
    parameter int IO_ADDR_W    = 32,
    parameter int EXT_ADDR_W   = 10,
    parameter int EXT_PERIOD_W = 10,
    parameter int MEM_ADDR_W   = 10
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    run,
    input  logic                    int_cnt_en,
    output logic                    done,
    input  logic [IO_ADDR_W-1:0]    ext_addr,
    input  logic [MEM_ADDR_W-1:0]   int_addr,
    input  logic [1:0]              direction,
    input  logic [EXT_ADDR_W-1:0]   iterations,
    input  logic [EXT_PERIOD_W-1:0] period,
    input  logic [EXT_ADDR_W-1:0]   start,
    input  logic [EXT_ADDR_W-1:0]   incr,
    input  logic [EXT_ADDR_W-1:0]   shift,
`ifdef EXT_ADDRGEN_STALL_CNT_EN
    output logic [31:0]             stall_cnt,
`endif
    ext_burst_addrgen_if.master     bus
);
    localparam int BYTE_SHIFT = $clog2(DATA_W / 8);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        EXT2INT = 2'd1,
        INT2EXT = 2'd2
    } state_t;

    state_t                  state;
    logic [IO_ADDR_W-1:0]    ext_addr_q;
    logic [MEM_ADDR_W-1:0]   int_addr_q;
    logic [EXT_ADDR_W-1:0]   iter_q;
    logic [EXT_PERIOD_W-1:0] period_q;
    logic [EXT_ADDR_W-1:0]   incr_q;
    logic [EXT_ADDR_W-1:0]   shift_q;
    logic [EXT_ADDR_W-1:0]   offset;
    logic [EXT_ADDR_W-1:0]   row;
    logic [EXT_PERIOD_W-1:0] beat;
    logic [MEM_ADDR_W-1:0]   int_cnt;

    logic cfg_ok;
    logic start_ok;
    logic active;
    logic row_end;

    assign cfg_ok   = (iterations != '0) && (period != '0) &&
                      ((direction == 2'b01) || (direction == 2'b10));
    assign start_ok = (state == IDLE) && run && cfg_ok;
    assign active   = (state != IDLE);
    assign row_end  = (beat == period_q - EXT_PERIOD_W'(1));

    // Sequencer: latches configuration on start, then walks beats/rows while the bus accepts
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            ext_addr_q <= '0;
            int_addr_q <= '0;
            iter_q     <= '0;
            period_q   <= '0;
            incr_q     <= '0;
            shift_q    <= '0;
            offset     <= '0;
            row        <= '0;
            beat       <= '0;
            int_cnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_ok) begin
                        ext_addr_q <= ext_addr;
                        int_addr_q <= int_addr;
                        iter_q     <= iterations;
                        period_q   <= period;
                        incr_q     <= incr;
                        shift_q    <= shift;
                        offset     <= start;
                        row        <= '0;
                        beat       <= '0;
                        int_cnt    <= '0;
                        state      <= (direction == 2'b01) ? EXT2INT : INT2EXT;
                    end
                end
                default: begin
                    if (bus.databus_ready) begin
                        if (row_end) begin
                            offset <= offset + shift_q;
                            beat   <= '0;
                            row    <= row + EXT_ADDR_W'(1);
                            if (row == iter_q - EXT_ADDR_W'(1)) begin
                                state <= IDLE;
                            end
                        end else begin
                            offset <= offset + incr_q;
                            beat   <= beat + EXT_PERIOD_W'(1);
                        end
                        // writes to the external side only consume internal words when asked to
                        if ((state == EXT2INT) || int_cnt_en) begin
                            int_cnt <= int_cnt + MEM_ADDR_W'(1);
                        end
                    end
                end
            endcase
        end
    end

    // Output decode from the registered state and counters
    always_comb begin
        done               = (state == IDLE);
        bus.databus_valid  = active;
        bus.databus_addr   = ext_addr_q + (IO_ADDR_W'(offset) << BYTE_SHIFT);
        bus.databus_len    = period_q - EXT_PERIOD_W'(1);
        bus.databus_last   = active && row_end;
        bus.databus_wdata  = bus.data_in;
        bus.databus_wstrb  = (state == INT2EXT) ? '1 : '0;
        bus.valid          = (state == INT2EXT) || ((state == EXT2INT) && bus.databus_ready);
        bus.we             = (state == EXT2INT) && bus.databus_ready;
        bus.addr           = int_addr_q + int_cnt;
        bus.data_out       = bus.databus_rdata;
    end

`ifdef EXT_ADDRGEN_STALL_CNT_EN
    // Saturating count of cycles the bus held off an outstanding beat
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt <= '0;
        end else if (start_ok) begin
            stall_cnt <= '0;
        end else if (active && !bus.databus_ready && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_ext_burst_addrgen.sv
// tb/tb_ext_burst_addrgen.sv - directed self-checking bench for ext_burst_addrgen
module tb_ext_burst_addrgen;
    localparam int DATA_W       = 32;
    localparam int IO_ADDR_W    = 32;
    localparam int EXT_ADDR_W   = 10;
    localparam int EXT_PERIOD_W = 10;
    localparam int MEM_ADDR_W   = 10;

    logic                    clk = 1'b0;
    logic                    rst = 1'b0;
    logic                    run = 1'b0;
    logic                    int_cnt_en = 1'b0;
    logic                    done;
    logic [IO_ADDR_W-1:0]    ext_addr = '0;
    logic [MEM_ADDR_W-1:0]   int_addr = '0;
    logic [1:0]              direction = '0;
    logic [EXT_ADDR_W-1:0]   iterations = '0;
    logic [EXT_PERIOD_W-1:0] period = '0;
    logic [EXT_ADDR_W-1:0]   start = '0;
    logic [EXT_ADDR_W-1:0]   incr = '0;
    logic [EXT_ADDR_W-1:0]   shift = '0;
`ifdef EXT_ADDRGEN_STALL_CNT_EN
    logic [31:0]             stall_cnt;
`endif

    ext_burst_addrgen_if #(
        .DATA_W(DATA_W), .IO_ADDR_W(IO_ADDR_W),
        .EXT_PERIOD_W(EXT_PERIOD_W), .MEM_ADDR_W(MEM_ADDR_W)
    ) bus ();

    ext_burst_addrgen #(
        .DATA_W(DATA_W), .IO_ADDR_W(IO_ADDR_W), .EXT_ADDR_W(EXT_ADDR_W),
        .EXT_PERIOD_W(EXT_PERIOD_W), .MEM_ADDR_W(MEM_ADDR_W)
    ) dut (
        .clk(clk), .rst(rst), .run(run), .int_cnt_en(int_cnt_en), .done(done),
        .ext_addr(ext_addr), .int_addr(int_addr), .direction(direction),
        .iterations(iterations), .period(period), .start(start),
        .incr(incr), .shift(shift),
`ifdef EXT_ADDRGEN_STALL_CNT_EN
        .stall_cnt(stall_cnt),
`endif
        .bus(bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present a configuration with run for one cycle, then scramble the inputs
    task automatic start_xfer(input logic [1:0] dir, input int it, input int per,
                              input int st, input int inc, input int sh,
                              input logic [31:0] ea, input int ia);
        direction  = dir;
        iterations = EXT_ADDR_W'(it);
        period     = EXT_PERIOD_W'(per);
        start      = EXT_ADDR_W'(st);
        incr       = EXT_ADDR_W'(inc);
        shift      = EXT_ADDR_W'(sh);
        ext_addr   = ea;
        int_addr   = MEM_ADDR_W'(ia);
        run        = 1'b1;
        @(negedge clk);
        run        = 1'b0;
        ext_addr   = 32'hFFFF_0000;
        int_addr   = '1;
        iterations = 10'd7;
        period     = 10'd9;
        start      = 10'd100;
        incr       = 10'd3;
        shift      = 10'd50;
        direction  = 2'b11;
    endtask

    logic [31:0] exp_a1 [6] = '{32'h1000, 32'h1004, 32'h1008, 32'h101C, 32'h1020, 32'h1024};
    logic [9:0]  exp_m2 [4] = '{10'h20, 10'h21, 10'h21, 10'h22};
    logic        en_seq [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic [31:0] exp_a6 [2] = '{32'h1000, 32'h1FFC};

    initial begin
        bus.databus_ready = 1'b0;
        bus.databus_rdata = '0;
        bus.data_in       = '0;

        // reset state, applied without any clock edge
        #2;
        check("rst_done", done, 1);
        check("rst_dvalid", bus.databus_valid, 0);
        check("rst_valid", bus.valid, 0);
        check("rst_we", bus.we, 0);
        check("rst_wstrb", bus.databus_wstrb, 0);
        check("rst_last", bus.databus_last, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        bus.databus_ready = 1'b1;

        // ext->int, 2 rows of 3, shift 5
        start_xfer(2'b01, 2, 3, 0, 1, 5, 32'h1000, 0);
        for (int i = 0; i < 6; i++) begin
            bus.databus_rdata = 32'hA000 + i;
            #1;
            check($sformatf("t1_dvalid%0d", i), bus.databus_valid, 1);
            check($sformatf("t1_daddr%0d", i), bus.databus_addr, exp_a1[i]);
            check($sformatf("t1_last%0d", i), bus.databus_last, (i == 2 || i == 5));
            check($sformatf("t1_len%0d", i), bus.databus_len, 2);
            check($sformatf("t1_maddr%0d", i), bus.addr, i);
            check($sformatf("t1_we%0d", i), bus.we, 1);
            check($sformatf("t1_wstrb%0d", i), bus.databus_wstrb, 0);
            check($sformatf("t1_dout%0d", i), bus.data_out, 32'hA000 + i);
            check($sformatf("t1_done%0d", i), done, 0);
            @(negedge clk);
        end
        #1;
        check("t1_done_end", done, 1);
        check("t1_dvalid_end", bus.databus_valid, 0);
        check("t1_we_end", bus.we, 0);

        // int->ext, one row of 4, internal advance gated
        @(negedge clk);
        start_xfer(2'b10, 1, 4, 0, 1, 0, 32'h0, 32'h20);
        for (int i = 0; i < 4; i++) begin
            int_cnt_en  = en_seq[i];
            bus.data_in = 32'h5500 + i;
            run         = (i == 1);
            #1;
            check($sformatf("t2_wstrb%0d", i), bus.databus_wstrb, 4'hF);
            check($sformatf("t2_maddr%0d", i), bus.addr, exp_m2[i]);
            check($sformatf("t2_valid%0d", i), bus.valid, 1);
            check($sformatf("t2_we%0d", i), bus.we, 0);
            check($sformatf("t2_wdata%0d", i), bus.databus_wdata, 32'h5500 + i);
            check($sformatf("t2_daddr%0d", i), bus.databus_addr, 4 * i);
            check($sformatf("t2_last%0d", i), bus.databus_last, (i == 3));
            @(negedge clk);
        end
        run = 1'b0;
        int_cnt_en = 1'b0;
        #1;
        check("t2_done_end", done, 1);

        // stall for 3 cycles at beat 2
        @(negedge clk);
        start_xfer(2'b01, 1, 4, 0, 1, 0, 32'h1000, 0);
        for (int i = 0; i < 2; i++) @(negedge clk);
        bus.databus_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check($sformatf("t3_daddr%0d", i), bus.databus_addr, 32'h1008);
            check($sformatf("t3_maddr%0d", i), bus.addr, 2);
            check($sformatf("t3_we%0d", i), bus.we, 0);
            check($sformatf("t3_dvalid%0d", i), bus.databus_valid, 1);
            check($sformatf("t3_last%0d", i), bus.databus_last, 0);
            @(negedge clk);
        end
        bus.databus_ready = 1'b1;
        #1;
        check("t3_resume_addr", bus.databus_addr, 32'h1008);
        @(negedge clk);
        #1;
        check("t3_resume_addr2", bus.databus_addr, 32'h100C);
        check("t3_resume_last", bus.databus_last, 1);
        @(negedge clk);
        #1;
        check("t3_done_end", done, 1);
`ifdef EXT_ADDRGEN_STALL_CNT_EN
        check("t3_stall_cnt", stall_cnt, 3);
`endif

        // rejected starts
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            direction  = (k == 2) ? 2'b11 : 2'b01;
            iterations = (k == 0) ? 10'd0 : 10'd2;
            period     = (k == 1) ? 10'd0 : 10'd3;
            run        = 1'b1;
            @(negedge clk);
            run = 1'b0;
            for (int j = 0; j < 2; j++) begin
                #1;
                check($sformatf("t4_done%0d_%0d", k, j), done, 1);
                check($sformatf("t4_dvalid%0d_%0d", k, j), bus.databus_valid, 0);
                @(negedge clk);
            end
        end

        // reset during beat 2 of a 6-beat int->ext transfer
        int_cnt_en = 1'b1;
        start_xfer(2'b10, 2, 3, 4, 1, 1, 32'h1000, 32'h40);
        #1;
        check("t5_b0_maddr", bus.addr, 32'h40);
        check("t5_b0_daddr", bus.databus_addr, 32'h1010);
        @(negedge clk);
        @(negedge clk);
        #1;
        check("t5_b2_maddr", bus.addr, 32'h42);
        #1;
        rst = 1'b0;
        #1;
        check("t5_rst_done", done, 1);
        check("t5_rst_dvalid", bus.databus_valid, 0);
        check("t5_rst_valid", bus.valid, 0);
        check("t5_rst_wstrb", bus.databus_wstrb, 0);
        check("t5_rst_last", bus.databus_last, 0);
        @(negedge clk);
        #1;
        check("t5_rst_hold", done, 1);
        rst = 1'b1;
        @(negedge clk);
        start_xfer(2'b10, 2, 3, 4, 1, 1, 32'h1000, 32'h40);
        #1;
        check("t5_re_daddr", bus.databus_addr, 32'h1010);
        check("t5_re_maddr", bus.addr, 32'h40);
        for (int i = 0; i < 6; i++) @(negedge clk);
        #1;
        check("t5_re_done", done, 1);
        int_cnt_en = 1'b0;

        // negative increment wraps the offset
        @(negedge clk);
        start_xfer(2'b01, 1, 2, 0, 10'h3FF, 0, 32'h1000, 0);
        for (int i = 0; i < 2; i++) begin
            #1;
            check($sformatf("t6_daddr%0d", i), bus.databus_addr, exp_a6[i]);
            check($sformatf("t6_last%0d", i), bus.databus_last, (i == 1));
            @(negedge clk);
        end
        #1;
        check("t6_done", done, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ext_burst_addrgen.md
EXT_BURST_ADDRGEN -- requirements
Module: ext_burst_addrgen

Interface
REQ-001 Parameter DATA_W, 32, data width in bits (multiple of 8, at least 16).
REQ-002 Parameter IO_ADDR_W, 32, external byte-address width.
REQ-003 Parameter EXT_ADDR_W, 10, external word-offset width.
REQ-004 Parameter EXT_PERIOD_W, 10, inner-loop (row length) counter width.
REQ-005 Parameter MEM_ADDR_W, 10, internal memory address width.
REQ-006 Ports SHALL be: clk in 1 clock; rst in 1 reset, asynchronous, active-low; one clock; reset is asynchronous and active-low.
REQ-007 run in 1 start pulse; int_cnt_en in 1 internal-advance enable for INT2EXT; done out 1 idle flag.
REQ-008 ext_addr in IO_ADDR_W base; int_addr in MEM_ADDR_W base; direction in 2 (01 ext->int, 10 int->ext).
REQ-009 iterations in EXT_ADDR_W rows; period in EXT_PERIOD_W words per row; start in EXT_ADDR_W first offset; incr, shift in EXT_ADDR_W signed intra-row step and row-end step.
REQ-010 databus_valid out 1; databus_ready in 1; databus_addr out IO_ADDR_W; databus_len out EXT_PERIOD_W beats-1 of current row; databus_last out 1 final beat of row; databus_rdata in DATA_W; databus_wdata out DATA_W; databus_wstrb out DATA_W/8.
REQ-011 valid out 1, we out 1, addr out MEM_ADDR_W, data_out out DATA_W, data_in in DATA_W: internal memory port.

Function
REQ-012 States SHALL be IDLE, EXT2INT, INT2EXT; done=1 only in IDLE.
REQ-013 In IDLE, run=1 with iterations!=0, period!=0 and direction 01/10 SHALL latch all configuration, load offset=start, row=0, beat=0, int counter=0, and enter EXT2INT/INT2EXT next cycle; otherwise run is ignored.
REQ-014 run while not IDLE SHALL be ignored; configuration inputs changes after the start cycle SHALL have no effect.
REQ-015 databus_addr SHALL equal latched ext_addr + (offset << log2(DATA_W/8)), modulo 2^IO_ADDR_W; offset arithmetic modulo 2^EXT_ADDR_W.
REQ-016 In active states databus_valid=1 continuously; a beat completes on the cycle databus_ready=1.
REQ-017 On a completed beat with beat<period-1: offset+=incr, beat+=1; with beat=period-1: offset+=shift, beat=0, row+=1.
REQ-018 databus_last SHALL be 1 when beat=period-1; databus_len SHALL equal latched period-1 throughout.
REQ-019 Completing the last beat of row iterations-1 SHALL return to IDLE next cycle; databus_valid low that next cycle.
REQ-020 EXT2INT: wstrb=0; valid=we=1 only in cycles databus_ready=1; data_out=databus_rdata; int counter+1 per completed beat.
REQ-021 INT2EXT: valid=1, we=0, wstrb all ones whenever databus_valid=1; databus_wdata=data_in; int counter+1 only on beats with int_cnt_en=1.
REQ-022 addr SHALL equal latched int_addr + int counter, modulo 2^MEM_ADDR_W; counter wraps silently.
REQ-023 databus_ready=0 SHALL freeze offset, beat, row, int counter and all outputs.
REQ-024 Total latency: iterations*period beats plus 1 start cycle plus 1 exit cycle when ready is held high.

Reset
REQ-025 rst=0 at any time SHALL force IDLE, counters and offset 0, done=1, databus_valid=valid=we=0, wstrb=0, databus_last=0, effective without clk.
REQ-026 Reset mid-transfer SHALL abandon the transfer; no beat completes while rst=0.

Configuration
REQ-027 Macro EXT_ADDRGEN_STALL_CNT_EN SHALL, when defined, add output stall_cnt (32 bits) counting cycles with databus_valid=1 and databus_ready=0, cleared on a run start and on reset, saturating at all ones.
REQ-028 Without EXT_ADDRGEN_STALL_CNT_EN the port and counter SHALL not exist; all other behaviour identical.

Verification
REQ-029 ext_addr=0x1000, dir=01, iterations=2, period=3, start=0, incr=1, shift=5, ready=1 -> addrs 0x1000,0x1004,0x1008,0x101C,0x1020,0x1024; last on beats 3,6; addr 0..5; done back after 8 cycles.
REQ-030 dir=10, iterations=1, period=4, int_cnt_en toggling 1,0,1,0 -> wstrb=0xF on all 4 beats, int addr sequence 0,1,1,2.
REQ-031 ready low 3 cycles mid-row -> outputs frozen; stall_cnt=3 with macro defined.
REQ-032 iterations=0 or period=0 or direction=11 with run -> done stays 1, databus_valid never asserts.
REQ-033 rst low during beat 2 of a 6-beat transfer -> immediate IDLE, done=1; new run restarts from start offset and int counter 0.
REQ-034 incr=-1 (all ones), start=0, period=2 -> offsets 0, 2^EXT_ADDR_W-1 (wrap), byte address scaled accordingly.
